// File: rtl/pll_mon_pkg.sv
// Shared state encoding and default timing for the PLL lock monitor.
package pll_mon_pkg;

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_STABLE = 2'd1,
    ST_HOLD   = 2'd2,
    ST_RUN    = 2'd3
  } state_e;

  localparam int DEF_SYNC_STAGES        = 2;
  localparam int DEF_LOCK_STABLE_CYCLES = 1024;
  localparam int DEF_RESET_HOLD_CYCLES  = 16;
  localparam int DEF_CNT_W              = 8;

  // A count of 1 still needs a 1-bit counter, so never return zero width.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Generic N-stage synchronizer for asynchronous flags entering a PLL clock domain.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (clr) chain <= '0;
    else     chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_lock_monitor.sv
// Qualifies the PLL lock flag, sequences the downstream system reset and tracks loss-of-lock events.
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_WAIT   | no synchronized lock; sys_rst held
// ST_STABLE | counting consecutive lock-high cycles; sys_rst held
// ST_HOLD   | lock qualified, stretching sys_rst for the hold window
// ST_RUN    | sys_rst released, ready high; any lock drop is a loss
module pll_lock_monitor
  import pll_mon_pkg::*;
#(
  parameter int SYNC_STAGES        = DEF_SYNC_STAGES,
  parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
  parameter int RESET_HOLD_CYCLES  = DEF_RESET_HOLD_CYCLES,
  parameter int CNT_W              = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             locked,
  input  logic             lost_clr,
  output logic             sys_rst,
  output logic             ready,
  output logic             lock_lost,
  output logic [CNT_W-1:0] lost_count
);

  localparam int SW = cnt_width(LOCK_STABLE_CYCLES);
  localparam int HW = cnt_width(RESET_HOLD_CYCLES);
  localparam logic [SW-1:0]    STAB_LAST = SW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [HW-1:0]    HOLD_LAST = HW'(RESET_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic          lk_s;
  state_e        state, state_nxt;
  logic [SW-1:0] stab_cnt, stab_nxt;
  logic [HW-1:0] hold_cnt, hold_nxt;
  logic          loss;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .clr (rst),
    .d   (locked),
    .q   (lk_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_WAIT;
      stab_cnt <= '0;
      hold_cnt <= '0;
      sys_rst  <= 1'b1;
      ready    <= 1'b0;
    end else begin
      state    <= state_nxt;
      stab_cnt <= stab_nxt;
      hold_cnt <= hold_nxt;
      // Outputs registered from the next state so they switch on the same edge as the FSM.
      sys_rst  <= (state_nxt != ST_RUN);
      ready    <= (state_nxt == ST_RUN);
    end
  end

  always_comb begin
    state_nxt = state;
    stab_nxt  = stab_cnt;
    hold_nxt  = hold_cnt;
    loss      = 1'b0;
    case (state)
      ST_WAIT: begin
        stab_nxt = '0;
        hold_nxt = '0;
        if (lk_s) state_nxt = ST_STABLE;
      end
      ST_STABLE: begin
        if (!lk_s) begin
          state_nxt = ST_WAIT;
          stab_nxt  = '0;
        end else if (stab_cnt == STAB_LAST) begin
          state_nxt = ST_HOLD;
          stab_nxt  = '0;
          hold_nxt  = '0;
        end else begin
          stab_nxt = stab_cnt + SW'(1);
        end
      end
      ST_HOLD: begin
        if (!lk_s) begin
          state_nxt = ST_WAIT;
          hold_nxt  = '0;
        end else if (hold_cnt == HOLD_LAST) begin
          state_nxt = ST_RUN;
          hold_nxt  = '0;
        end else begin
          hold_nxt = hold_cnt + HW'(1);
        end
      end
      ST_RUN: begin
        if (!lk_s) begin
          state_nxt = ST_WAIT;
          loss      = 1'b1;
        end
      end
      default: state_nxt = ST_WAIT;
    endcase
  end

  // A loss on the same edge as a clear wins: the event survives as a count of one.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_lost  <= 1'b0;
      lost_count <= '0;
    end else if (loss) begin
      lock_lost <= 1'b1;
      if (lost_clr)                lost_count <= CNT_W'(1);
      else if (lost_count != CNT_MAX) lost_count <= lost_count + CNT_W'(1);
    end else if (lost_clr) begin
      lock_lost  <= 1'b0;
      lost_count <= '0;
    end
  end

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Table-driven bench for pll_lock_monitor with a per-cycle expected-value scoreboard.
module tb_pll_lock_monitor;

  localparam int SYNC = 2;
  localparam int STAB = 8;
  localparam int HOLD = 4;
  localparam int CW   = 2;
  localparam int QUAL = SYNC + STAB + HOLD + 1;

  logic          clk = 1'b0;
  logic          rst, locked, lost_clr;
  logic          sys_rst, ready, lock_lost;
  logic [CW-1:0] lost_count;

  always #5 clk = ~clk;

  pll_lock_monitor #(
    .SYNC_STAGES        (SYNC),
    .LOCK_STABLE_CYCLES (STAB),
    .RESET_HOLD_CYCLES  (HOLD),
    .CNT_W              (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .locked     (locked),
    .lost_clr   (lost_clr),
    .sys_rst    (sys_rst),
    .ready      (ready),
    .lock_lost  (lock_lost),
    .lost_count (lost_count)
  );

  typedef struct {
    logic          rst;
    logic          locked;
    logic          clr;
    int            n;
    logic          sr;
    logic          ll;
    logic [CW-1:0] lc;
  } vec_t;

  typedef struct {
    logic          sr;
    logic          ll;
    logic [CW-1:0] lc;
    int            row;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic add(input logic r, input logic l, input logic c, input int n,
                     input logic sr, input logic ll, input logic [CW-1:0] lc);
    vec_t v;
    v.rst = r; v.locked = l; v.clr = c; v.n = n; v.sr = sr; v.ll = ll; v.lc = lc;
    vecs.push_back(v);
  endtask

  // Full qualification from WAIT with locked held high: sys_rst drops on the QUAL-th edge.
  task automatic qualify(input logic ll, input logic [CW-1:0] lc);
    add(1'b0, 1'b1, 1'b0, QUAL - 1, 1'b1, ll, lc);
    add(1'b0, 1'b1, 1'b0, 1,        1'b0, ll, lc);
  endtask

  task automatic cmp(input string name, input int row, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t e;
    int   lc;
    int   k;

    rst = 1'b1; locked = 1'b0; lost_clr = 1'b0;

    // power-up reset, then glitch during qualification restarts it
    add(1'b1, 1'b0, 1'b0, 3, 1'b1, 1'b0, 2'd0);
    add(1'b0, 1'b1, 1'b0, 5, 1'b1, 1'b0, 2'd0);
    add(1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b0, 2'd0);
    qualify(1'b0, 2'd0);
    add(1'b0, 1'b1, 1'b0, 3, 1'b0, 1'b0, 2'd0);
    // first loss in RUN: sys_rst back on the third edge
    add(1'b0, 1'b0, 1'b0, 2, 1'b0, 1'b0, 2'd0);
    add(1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b1, 2'd1);
    add(1'b0, 1'b0, 1'b0, 2, 1'b1, 1'b1, 2'd1);
    // requalify, second loss
    qualify(1'b1, 2'd1);
    add(1'b0, 1'b0, 1'b0, 2, 1'b0, 1'b1, 2'd1);
    add(1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b1, 2'd2);
    // lost_clr alone in RUN leaves the state alone
    qualify(1'b1, 2'd2);
    add(1'b0, 1'b1, 1'b1, 1, 1'b0, 1'b0, 2'd0);
    add(1'b0, 1'b1, 1'b0, 2, 1'b0, 1'b0, 2'd0);
    // lost_clr on the loss edge: loss wins
    add(1'b0, 1'b0, 1'b0, 2, 1'b0, 1'b0, 2'd0);
    add(1'b0, 1'b0, 1'b1, 1, 1'b1, 1'b1, 2'd1);
    // saturation at 3 with CNT_W=2
    lc = 1;
    for (int i = 0; i < 4; i++) begin
      qualify(1'b1, CW'(lc));
      add(1'b0, 1'b0, 1'b0, 2, 1'b0, 1'b1, CW'(lc));
      lc = (lc < 3) ? lc + 1 : 3;
      add(1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b1, CW'(lc));
    end
    // reset mid-RUN, then requalify with locked still high
    qualify(1'b1, 2'd3);
    add(1'b1, 1'b1, 1'b0, 1, 1'b1, 1'b0, 2'd0);
    qualify(1'b0, 2'd0);

    step();
    for (int r = 0; r < vecs.size(); r++) begin
      for (int c = 0; c < vecs[r].n; c++) begin
        rst      = vecs[r].rst;
        locked   = vecs[r].locked;
        lost_clr = vecs[r].clr;
        e.sr = vecs[r].sr; e.ll = vecs[r].ll; e.lc = vecs[r].lc; e.row = r;
        sb.push_back(e);
        step();
        e = sb.pop_front();
        cmp("sys_rst",    e.row, {7'd0, sys_rst},    {7'd0, e.sr});
        cmp("ready",      e.row, {7'd0, ready},      {7'd0, ~e.sr});
        cmp("lock_lost",  e.row, {7'd0, lock_lost},  {7'd0, e.ll});
        cmp("lost_count", e.row, {6'd0, lost_count}, {6'd0, e.lc});
      end
    end
    rst = 1'b0; lost_clr = 1'b0;

    // loss latency measured directly, with a bounded wait
    locked = 1'b0;
    k = 0;
    do begin
      step();
      k++;
    end while (sys_rst !== 1'b1 && k < 20);
    cmp("loss_latency",    -1, 8'(k), 8'(SYNC + 1));
    cmp("loss_ready",      -1, {7'd0, ready},      8'd0);
    cmp("loss_lock_lost",  -1, {7'd0, lock_lost},  8'd1);
    cmp("loss_lost_count", -1, {6'd0, lost_count}, 8'd1);
    cmp("scoreboard_empty", -1, 8'(sb.size()), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
